// File: rtl/usb_utmi_pkg.sv
// Shared UTMI transmit-side types.
package usb_utmi_pkg;

  typedef logic [7:0] bus8_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } tx_arb_state_t;

endpackage

// File: rtl/usb_rr_pick.sv
// Combinational round-robin selector: first asserted request after i_last, wrapping.
module usb_rr_pick #(
  parameter  int N_REQ = 2,
  localparam int IW    = $clog2(N_REQ)
)(
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_last,
  output logic [IW-1:0]    o_next,
  output logic             o_any
);

  int            w_sum;
  logic [IW-1:0] w_idx;
  logic          w_hit;

  // Modulo done by a single conditional subtract so a non-power-of-two
  // N_REQ can never produce an out-of-range index.
  always_comb begin
    o_next = i_last;
    w_hit  = 1'b0;
    w_sum  = 0;
    w_idx  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_sum = int'(i_last) + k;
      if (w_sum >= N_REQ) w_sum = w_sum - N_REQ;
      w_idx = IW'(w_sum);
      if (!w_hit && i_req[w_idx]) begin
        o_next = w_idx;
        w_hit  = 1'b1;
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/usb_utmi_tx_arb.sv
// UTMI transmit arbiter: round-robin packet grants with a programmable inter-packet gap.
module usb_utmi_tx_arb
  import usb_utmi_pkg::*;
#(
  parameter  int N_REQ      = 2,
  parameter  int IPG_CYCLES = 8,
  localparam int IW         = $clog2(N_REQ),
  localparam int CW         = $clog2(IPG_CYCLES + 1)
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               suspend_m,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*8-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output bus8_t              data_in,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic [IW-1:0]      gnt_id
);

  tx_arb_state_t     r_state;
  logic [IW-1:0]     r_gnt_id;
  logic [CW-1:0]     r_gap_cnt;

  bus8_t [N_REQ-1:0] w_data;
  logic [IW-1:0]     w_pick;
  logic              w_any;
  logic              w_cur_vld;

  assign w_data    = req_data;
  assign w_cur_vld = req_valid[r_gnt_id];

  usb_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .i_req  (req_valid),
    .i_last (r_gnt_id),
    .o_next (w_pick),
    .o_any  (w_any)
  );

  // gnt_id resets to the last index so requester 0 wins the first round.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_gnt_id  <= IW'(N_REQ - 1);
      r_gap_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: if (suspend_m && w_any) begin
          r_gnt_id <= w_pick;
          r_state  <= GRANT;
        end
        GRANT: if (!w_cur_vld) begin
          r_state   <= GAP;
          r_gap_cnt <= CW'(IPG_CYCLES - 1);
        end
        GAP: begin
          if (r_gap_cnt == '0) r_state <= IDLE;
          else                 r_gap_cnt <= r_gap_cnt - CW'(1);
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from state, so an async reset kills tx_valid at once.
  always_comb begin
    tx_valid  = 1'b0;
    data_in   = '0;
    req_ready = '0;
    if (r_state == GRANT) begin
      tx_valid            = w_cur_vld;
      data_in             = w_data[r_gnt_id];
      req_ready[r_gnt_id] = tx_ready;
    end
  end

  assign busy   = (r_state != IDLE);
  assign gnt_id = r_gnt_id;

endmodule

// File: tb/tb_usb_utmi_tx_arb.sv
// Bench for usb_utmi_tx_arb: two instances (2 req / gap 8, 3 req / gap 1) against a cycle model.
module tb_usb_utmi_tx_arb;

  localparam int NA = 2, IA = 8, NB = 3, IB = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] vld  [2];
  logic [7:0] dat  [2][8];
  logic       sus  [2];
  logic       trdy [2];

  logic [NA-1:0]   a_vld, a_rdy;
  logic [NA*8-1:0] a_dat;
  logic [7:0]      a_din;
  logic            a_txv, a_busy, a_sus, a_trdy;
  logic [0:0]      a_gnt;
  logic [NB-1:0]   b_vld, b_rdy;
  logic [NB*8-1:0] b_dat;
  logic [7:0]      b_din;
  logic            b_txv, b_busy, b_sus, b_trdy;
  logic [1:0]      b_gnt;

  assign a_vld  = vld[0][NA-1:0];
  assign a_dat  = {dat[0][1], dat[0][0]};
  assign a_sus  = sus[0];
  assign a_trdy = trdy[0];
  assign b_vld  = vld[1][NB-1:0];
  assign b_dat  = {dat[1][2], dat[1][1], dat[1][0]};
  assign b_sus  = sus[1];
  assign b_trdy = trdy[1];

  usb_utmi_tx_arb #(.N_REQ(NA), .IPG_CYCLES(IA)) u_a (
    .clk(clk), .rst(rst), .suspend_m(a_sus), .req_valid(a_vld), .req_data(a_dat),
    .req_ready(a_rdy), .data_in(a_din), .tx_valid(a_txv), .tx_ready(a_trdy),
    .busy(a_busy), .gnt_id(a_gnt));

  usb_utmi_tx_arb #(.N_REQ(NB), .IPG_CYCLES(IB)) u_b (
    .clk(clk), .rst(rst), .suspend_m(b_sus), .req_valid(b_vld), .req_data(b_dat),
    .req_ready(b_rdy), .data_in(b_din), .tx_valid(b_txv), .tx_ready(b_trdy),
    .busy(b_busy), .gnt_id(b_gnt));

  // Reference model: owner = requester holding the bus (-1 none),
  // gap = idle cycles still owed, last = most recent grant.
  typedef struct {
    int owner;
    int gap;
    int last;
  } mdl_t;

  mdl_t m [2];
  int   nreq [2] = '{NA, NB};
  int   ipg  [2] = '{IA, IB};

  int         plen [2][8], ppos [2][8], npk [2][8], wt [2][8];
  int         wmax [2];
  logic [7:0] pbuf [2][8][8];
  logic [7:0] hs   [2];
  logic       s_txv [2], s_busy [2], prev_txv [2];
  int         glog0 [$], glog1 [$];
  int         n_tests = 0, n_fail = 0;
  int         cnt, ob;

  function automatic mdl_t mdl_reset(int n);
    mdl_t r;
    r.owner = -1;
    r.gap   = 0;
    r.last  = n - 1;
    return r;
  endfunction

  function automatic mdl_t mdl_step(mdl_t s, int n, int g, logic [7:0] v, logic su);
    mdl_t r = s;
    if (s.owner >= 0) begin
      if (!v[s.owner]) begin
        r.owner = -1;
        r.gap   = g;
      end
    end else if (s.gap > 0) begin
      r.gap = s.gap - 1;
    end else if (su && v != 8'h00) begin
      for (int k = 1; k <= n; k++) begin
        if (v[(s.last + k) % n]) begin
          r.owner = (s.last + k) % n;
          r.last  = r.owner;
          break;
        end
      end
    end
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int d = 0; d < 2; d++) begin
      vld[d] = 8'h00;
      for (int i = 0; i < 8; i++) begin
        dat[d][i] = 8'h00;
        if (i < nreq[d] && ppos[d][i] < plen[d][i]) begin
          vld[d][i] = 1'b1;
          dat[d][i] = pbuf[d][i][ppos[d][i]];
        end
      end
    end
  endtask

  task automatic load_rand(int d, int i);
    plen[d][i] = $urandom_range(1, 4);
    ppos[d][i] = 0;
    for (int j = 0; j < 8; j++) pbuf[d][i][j] = 8'($urandom);
  endtask

  task automatic gen_clear();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 8; i++) begin
        plen[d][i] = 0; ppos[d][i] = 0; npk[d][i] = 0; wt[d][i] = 0;
      end
  endtask

  // Requesters: advance on a handshake the model expects, drop valid after
  // the last byte, then optionally start another packet after a wait.
  task automatic gen_step();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < nreq[d]; i++) begin
        if (ppos[d][i] < plen[d][i]) begin
          if (hs[d][i]) begin
            ppos[d][i]++;
            if (ppos[d][i] == plen[d][i]) wt[d][i] = $urandom_range(0, wmax[d]);
          end
        end else if (wt[d][i] > 0) begin
          wt[d][i]--;
        end else if (npk[d][i] > 0) begin
          npk[d][i]--;
          load_rand(d, i);
        end
      end
  endtask

  task automatic check_all();
    logic       o_txv, o_busy, e_txv, e_busy;
    logic [7:0] o_din, o_rdy, o_gnt, e_din, e_rdy;
    int         ow;
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin
        o_txv = a_txv; o_din = a_din; o_rdy = {6'b0, a_rdy}; o_busy = a_busy; o_gnt = {7'b0, a_gnt};
      end else begin
        o_txv = b_txv; o_din = b_din; o_rdy = {5'b0, b_rdy}; o_busy = b_busy; o_gnt = {6'b0, b_gnt};
      end
      ow     = m[d].owner;
      e_txv  = (ow >= 0) && vld[d][ow];
      e_din  = (ow >= 0) ? dat[d][ow] : 8'h00;
      e_rdy  = 8'h00;
      if (ow >= 0) e_rdy[ow] = trdy[d];
      e_busy = (ow >= 0) || (m[d].gap > 0);
      chk($sformatf("tx_valid%0d", d), 32'(o_txv), 32'(e_txv));
      chk($sformatf("data_in%0d", d), 32'(o_din), 32'(e_din));
      chk($sformatf("req_ready%0d", d), 32'(o_rdy), 32'(e_rdy));
      chk($sformatf("busy%0d", d), 32'(o_busy), 32'(e_busy));
      chk($sformatf("gnt_id%0d", d), 32'(o_gnt), 32'(m[d].last));
      chk($sformatf("gnt_range%0d", d), 32'(int'(o_gnt) < nreq[d]), 32'd1);
      hs[d]     = e_txv ? e_rdy : 8'h00;
      s_txv[d]  = o_txv;
      s_busy[d] = o_busy;
      if (o_txv && !prev_txv[d]) begin
        if (d == 0) glog0.push_back(int'(o_gnt));
        else        glog1.push_back(int'(o_gnt));
      end
      prev_txv[d] = o_txv;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    check_all();
    @(posedge clk);
    for (int d = 0; d < 2; d++)
      m[d] = rst ? mdl_reset(nreq[d]) : mdl_step(m[d], nreq[d], ipg[d], vld[d], sus[d]);
    if (!rst) gen_step();
    #1 drive();
  endtask

  task automatic reset_on();
    rst = 1'b1;
    gen_clear();
    for (int d = 0; d < 2; d++) begin
      m[d] = mdl_reset(nreq[d]);
      prev_txv[d] = 1'b0;
      wmax[d] = 0;
    end
    drive();
  endtask

  task automatic reset_off();
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic drain(int d);
    for (int k = 0; k < 200; k++) begin
      if (!s_busy[d] && vld[d] == 8'h00) break;
      cyc();
    end
    chk($sformatf("drain%0d", d), 32'(s_busy[d]), 32'd0);
  endtask

  initial begin
    sus  = '{1'b1, 1'b1};
    trdy = '{1'b0, 1'b0};
    reset_on();
    reset_off();

    // Single requester, three bytes, tx_ready every 4th cycle.
    pbuf[0][0][0] = 8'h2D; pbuf[0][0][1] = 8'h00; pbuf[0][0][2] = 8'h10;
    plen[0][0] = 3; ppos[0][0] = 0;
    drive();
    for (int c = 0; c < 100 && ppos[0][0] < plen[0][0]; c++) begin
      trdy[0] = (c % 4 == 3);
      cyc();
    end
    trdy[0] = 1'b0;
    cyc();
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (!s_busy[0]) break;
      cnt++;
    end
    chk("A_busy_after_drop", cnt, IA);

    // Simultaneous requests straight out of reset; requester 0 re-requests.
    reset_on();
    load_rand(0, 0); load_rand(0, 1); npk[0][0] = 1;
    trdy[0] = 1'b1;
    drive();
    glog0.delete();
    reset_off();
    for (int k = 0; k < 200 && glog0.size() < 3; k++) cyc();
    chk("B_grant_count", 32'(glog0.size() >= 3), 32'd1);
    if (glog0.size() >= 3) begin
      chk("B_grant0", glog0[0], 0);
      chk("B_grant1", glog0[1], 1);
      chk("B_grant2", glog0[2], 0);
    end
    drain(0);

    // Suspend holds off a grant; dropping it mid-packet does not abort.
    sus[0] = 1'b0;
    pbuf[0][1][0] = 8'hA1; pbuf[0][1][1] = 8'hB2; pbuf[0][1][2] = 8'hC3;
    plen[0][1] = 3; ppos[0][1] = 0;
    drive();
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (s_txv[0]) cnt++;
    end
    chk("C_no_grant_suspended", cnt, 0);
    sus[0] = 1'b1;
    cyc();
    ob = (a_rdy[1] && a_txv) ? 1 : 0;
    cyc();
    chk("C_grant_next_cycle", 32'(s_txv[0]), 32'd1);
    chk("C_gnt_id", 32'(a_gnt), 32'd1);
    sus[0] = 1'b0;
    for (int k = 0; k < 20 && vld[0] != 8'h00; k++) begin
      #3 if (a_rdy[1] && a_txv) ob++;
      cyc();
    end
    chk("C_bytes_sent", ob, 3);
    sus[0] = 1'b1;
    drain(0);

    // Gap boundary, IPG=1: continuous requester 0, requester 1 arriving in GAP.
    trdy[1] = 1'b1;
    load_rand(1, 0); npk[1][0] = 1;
    drive();
    for (int k = 0; k < 50 && ppos[1][0] < plen[1][0]; k++) cyc();
    cyc();
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (s_txv[1]) break;
      cnt++;
    end
    chk("D_low_after_drop", cnt, IB + 1);
    npk[1][0] = 1;
    for (int k = 0; k < 50 && ppos[1][0] < plen[1][0]; k++) cyc();
    cyc();
    chk("D_in_gap", 32'(m[1].gap > 0), 32'd1);
    load_rand(1, 1);
    drive();
    glog1.delete();
    for (int k = 0; k < 50 && glog1.size() < 1; k++) cyc();
    chk("D_gap_req_count", 32'(glog1.size()), 32'd1);
    if (glog1.size() >= 1) chk("D_gap_req_wins", glog1[0], 1);
    drain(1);

    // Non-power-of-two rotation: 0,1,2,0.
    reset_on();
    load_rand(1, 0); load_rand(1, 1); load_rand(1, 2); npk[1][0] = 1;
    trdy[1] = 1'b1;
    drive();
    glog1.delete();
    reset_off();
    for (int k = 0; k < 200 && glog1.size() < 4; k++) cyc();
    chk("E_grant_count", 32'(glog1.size() >= 4), 32'd1);
    if (glog1.size() >= 4) begin
      chk("E_grant0", glog1[0], 0);
      chk("E_grant1", glog1[1], 1);
      chk("E_grant2", glog1[2], 2);
      chk("E_grant3", glog1[3], 0);
    end
    drain(1);

    // Asynchronous reset two bytes into a packet.
    trdy[0] = 1'b1;
    pbuf[0][0][0] = 8'h11; pbuf[0][0][1] = 8'h22; pbuf[0][0][2] = 8'h33; pbuf[0][0][3] = 8'h44;
    plen[0][0] = 4; ppos[0][0] = 0;
    drive();
    for (int k = 0; k < 20 && ppos[0][0] < 2; k++) cyc();
    #2;
    chk("F_txv_before_rst", 32'(a_txv), 32'd1);
    rst = 1'b1;
    #1;
    chk("F_txv_async", 32'(a_txv), 32'd0);
    chk("F_rdy_async", 32'(a_rdy), 32'd0);
    chk("F_busy_async", 32'(a_busy), 32'd0);
    reset_on();
    cyc();
    rst = 1'b0;
    cyc();
    chk("F_gnt_after_rst", 32'(a_gnt), NA - 1);
    load_rand(0, 0); load_rand(0, 1);
    drive();
    glog0.delete();
    for (int k = 0; k < 20 && glog0.size() < 1; k++) cyc();
    chk("F_restart_count", 32'(glog0.size()), 32'd1);
    if (glog0.size() >= 1) chk("F_restart_req0", glog0[0], 0);

    // Randomized traffic on both instances.
    wmax = '{3, 3};
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < nreq[d]; i++) npk[d][i] = 100000;
    for (int k = 0; k < 3000; k++) begin
      for (int d = 0; d < 2; d++) begin
        trdy[d] = ($urandom_range(0, 3) != 0);
        sus[d]  = ($urandom_range(0, 15) != 0);
      end
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
